// File: rtl/muldiv_hazard_pkg.sv
// Shared types and constants for the RV32IM hazard scheduler.
// State encodings, register-zero constant and divider defaults.
package muldiv_hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIV_ISSUE = 2'd1,
        ST_DIV_RUN   = 2'd2
    } sched_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int DIV_CYCLES_DEF = 34;
    localparam int CNT_W_DEF = 6;

    function automatic logic reg_match(
        input logic       uses,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return uses && (rs == rd) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/muldiv_hazard_scheduler_if.sv
// ID/EX hazard information in, pipeline stall/bubble/flush controls out.
// slave = scheduler side, master = pipeline side.
interface muldiv_hazard_scheduler_if;

    logic [4:0] ID_RS1;
    logic [4:0] ID_RS2;
    logic       ID_USES_RS1;
    logic       ID_USES_RS2;
    logic       ID_IS_DIV;
    logic [4:0] EX_RD;
    logic       EX_MEM_READ;
    logic       EX_BRANCH_TAKEN;

    logic PC_STALL;
    logic IFID_STALL;
    logic IFID_FLUSH;
    logic IDEX_STALL;
    logic IDEX_BUBBLE;
    logic EXMEM_BUBBLE;
    logic DIV_START;
    logic DIV_BUSY;

    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        input  ID_IS_DIV, EX_RD, EX_MEM_READ, EX_BRANCH_TAKEN,
        output PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL,
        output IDEX_BUBBLE, EXMEM_BUBBLE, DIV_START, DIV_BUSY
    );

    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        output ID_IS_DIV, EX_RD, EX_MEM_READ, EX_BRANCH_TAKEN,
        input  PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL,
        input  IDEX_BUBBLE, EXMEM_BUBBLE, DIV_START, DIV_BUSY
    );

endinterface

// File: rtl/muldiv_hazard_scheduler_div_cycle_counter.sv
// Divider cycle counter: load, decrement and zero flag.
// Synchronous active-high reset clears it.
module div_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_hazard_scheduler.sv
// Load-use / divider / branch hazard scheduler for the RV32IM pipeline.
// Define STALL_PERF_CNT_EN to add the STALL_CYCLES performance counter.
module muldiv_hazard_scheduler
    import muldiv_hazard_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RESET,
    muldiv_hazard_scheduler_if.slave bus
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] STALL_CYCLES
`endif
);

    sched_state_e state, state_nxt;

    logic load_use, flush;
    logic cnt_load, cnt_dec, cnt_zero;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall;
    logic idex_bubble, exmem_bubble, div_start, div_busy;

    assign load_use = bus.EX_MEM_READ &&
        (reg_match(bus.ID_USES_RS1, bus.ID_RS1, bus.EX_RD) ||
         reg_match(bus.ID_USES_RS2, bus.ID_RS2, bus.EX_RD));
    assign flush = bus.EX_BRANCH_TAKEN;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        div_start    = 1'b0;
        div_busy     = 1'b0;
        if (!RESET) begin
            unique case (state)
                ST_IDLE: begin
                    // a taken branch squashes both the stall and any divide issue
                    pc_stall    = load_use && !flush;
                    ifid_stall  = load_use && !flush;
                    ifid_flush  = flush;
                    idex_bubble = load_use || flush;
                    if (bus.ID_IS_DIV && !load_use && !flush) begin
                        state_nxt = ST_DIV_ISSUE;
                    end
                end
                ST_DIV_ISSUE: begin
                    div_start    = 1'b1;
                    cnt_load     = 1'b1;
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    state_nxt    = ST_DIV_RUN;
                end
                ST_DIV_RUN: begin
                    // zero count: result lands in EX/MEM, pipeline released
                    if (cnt_zero) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        div_busy     = 1'b1;
                        cnt_dec      = 1'b1;
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_stall   = 1'b1;
                        exmem_bubble = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    div_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_div_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (CNT_W'(DIV_CYCLES - 2)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign bus.PC_STALL     = pc_stall;
    assign bus.IFID_STALL   = ifid_stall;
    assign bus.IFID_FLUSH   = ifid_flush;
    assign bus.IDEX_STALL   = idex_stall;
    assign bus.IDEX_BUBBLE  = idex_bubble;
    assign bus.EXMEM_BUBBLE = exmem_bubble;
    assign bus.DIV_START    = div_start;
    assign bus.DIV_BUSY     = div_busy;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_CYCLES <= 32'd0;
        end else if (pc_stall) begin
            STALL_CYCLES <= STALL_CYCLES + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_hazard_scheduler.sv
// Self-checking bench for muldiv_hazard_scheduler (directed + random).
// Reference model tracks the EX-cycle index of an in-flight divide.
module tb_muldiv_hazard_scheduler;

    localparam int DC = 34;

    logic CLK = 1'b0;
    logic RESET;
    int compared = 0;
    int mismatched = 0;

    // model: kk = 0 when EX is free, else the divide's EX cycle number 1..DC
    int kk = 0;
    int perf_m = 0;
    int n_busy, n_start, n_stall;

    muldiv_hazard_scheduler_if bus();

`ifdef STALL_PERF_CNT_EN
    logic [31:0] STALL_CYCLES;
`endif

    muldiv_hazard_scheduler #(
        .DIV_CYCLES (DC),
        .CNT_W      (6)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
`ifdef STALL_PERF_CNT_EN
        ,
        .STALL_CYCLES (STALL_CYCLES)
`endif
    );

    always #5 CLK = ~CLK;

    logic [7:0] obs;
    assign obs = {bus.PC_STALL, bus.IFID_STALL, bus.IFID_FLUSH,
                  bus.IDEX_STALL, bus.IDEX_BUBBLE, bus.EXMEM_BUBBLE,
                  bus.DIV_START, bus.DIV_BUSY};

    function automatic logic hazard();
        if (!bus.EX_MEM_READ || bus.EX_RD == 5'd0) return 1'b0;
        return (bus.ID_USES_RS1 && bus.ID_RS1 == bus.EX_RD) ||
               (bus.ID_USES_RS2 && bus.ID_RS2 == bus.EX_RD);
    endfunction

    function automatic logic [7:0] model_out();
        logic lu, br;
        if (RESET) return 8'd0;
        if (kk == 0) begin
            lu = hazard();
            br = bus.EX_BRANCH_TAKEN;
            return {lu && !br, lu && !br, br, 1'b0, lu || br, 3'b000};
        end
        if (kk < DC) begin
            return {2'b11, 1'b0, 1'b1, 1'b0, 1'b1, kk == 1, kk >= 2};
        end
        return 8'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] ob,
                         input logic [31:0] ex);
        compared++;
        assert (ob === ex) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, ob, ex);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic dv,
                         input logic [4:0] rd, input logic mr,
                         input logic br);
        bus.ID_RS1 = rs1;
        bus.ID_RS2 = rs2;
        bus.ID_USES_RS1 = u1;
        bus.ID_USES_RS2 = u2;
        bus.ID_IS_DIV = dv;
        bus.EX_RD = rd;
        bus.EX_MEM_READ = mr;
        bus.EX_BRANCH_TAKEN = br;
    endtask

    task automatic quiet();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick(input string tag);
        logic [7:0] e;
        @(negedge CLK);
        e = model_out();
        check(tag, {24'd0, obs}, {24'd0, e});
`ifdef STALL_PERF_CNT_EN
        check({tag, "_perf"}, STALL_CYCLES, perf_m);
`endif
        n_busy += int'(bus.DIV_BUSY);
        n_start += int'(bus.DIV_START);
        n_stall += int'(bus.PC_STALL);
        @(posedge CLK);
        if (RESET) begin
            kk = 0;
            perf_m = 0;
        end else begin
            if (e[7]) perf_m++;
            if (kk == 0) begin
                kk = (bus.ID_IS_DIV && !hazard() && !bus.EX_BRANCH_TAKEN)
                     ? 1 : 0;
            end else if (kk == DC) begin
                kk = 0;
            end else begin
                kk++;
            end
        end
        #1;
    endtask

    initial begin
        // reset with a load-use pattern present: outputs stay low
        RESET = 1'b1;
        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick("reset0");
        tick("reset1");
        RESET = 1'b0;
        quiet();
        tick("idle");

        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick("t1_lu");
        quiet();
        tick("t1_after");

        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        tick("t2_x0");
        drive(5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick("t2_rs2_unused");
        drive(5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick("t2_rs2_used");

        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        tick("t4_lu_branch");
        quiet();
        tick("t4_after");

        // single divide, with load/branch noise ignored while EX is held
        RESET = 1'b1;
        tick("t3_rst");
        RESET = 1'b0;
        n_busy = 0;
        n_start = 0;
        n_stall = 0;
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick("t3_idle_div");
        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        for (int i = 0; i < DC + 1; i++) tick("t3_run");
        check("t3_busy_cycles", n_busy, 32);
        check("t3_start_cycles", n_start, 1);
        check("t3_stall_cycles", n_stall, 33);

        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick("t6_lu");
`ifdef STALL_PERF_CNT_EN
        check("t6_perf_total", STALL_CYCLES, 34);
`endif
        quiet();
        tick("t6_after");

        // reset during the 10th DIV_RUN cycle
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick("t5_idle_div");
        quiet();
        for (int i = 0; i < 10; i++) tick("t5_run");
        RESET = 1'b1;
        tick("t5_reset");
        RESET = 1'b0;
        tick("t5_after");
        n_start = 0;
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick("t5_redo");
        quiet();
        for (int i = 0; i < DC + 1; i++) tick("t5_redo_run");
        check("t5_restart", n_start, 1);

        // back-to-back: DIV held in ID across the first divide
        n_start = 0;
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 2 * DC + 2; i++) tick("b2b");
        check("b2b_starts", n_start, 2);
        quiet();
        for (int i = 0; i < DC; i++) tick("b2b_drain");

        for (int i = 0; i < 600; i++) begin
            RESET = ($urandom_range(0, 99) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
